vc_line_arbiter: RTL and testbench

Two-input AXI4-Stream arbiter that merges two single-virtual-channel YUV422 pixel streams into one tdest-tagged stream for the CSI-2 virtual-channel path. It is the inverse companion of the tdest-based stream switch and feeds it or any other consumer that demultiplexes on tdest. Arbitration is line-granular round-robin: a grant is held until the granted input's tlast beat is accepted, so lines are never interleaved. A beat-count watchdog forcibly terminates runaway lines.

---
 rtl/vc_line_arbiter.sv | 136 +++++++++++++
 tb/tb_vc_line_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_line_arbiter.sv
// vc_line_arbiter: line-granular round-robin merge of two AXI4-Stream inputs onto one
// tdest-tagged output, with a beat-count watchdog that cuts off runaway lines.
//   state | meaning
//   IDLE  | no owner, arbitrating between valid inputs
//   GNT0  | input 0 owns the output until its line ends
//   GNT1  | input 1 owns the output until its line ends
module vc_line_arbiter #(
    parameter int                     WIDTH          = 16,
    parameter int                     TUSER_WIDTH    = 1,
    parameter int                     TDEST_WIDTH    = 10,
    parameter logic [TDEST_WIDTH-1:0] VC0_DEST       = 10'h1e2,
    parameter logic [TDEST_WIDTH-1:0] VC1_DEST       = 10'h1e3,
    parameter int                     MAX_LINE_BEATS = 4096
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic [WIDTH-1:0]       s0_axis_tdata,
    input  logic                   s0_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s0_axis_tuser,
    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic [WIDTH-1:0]       s1_axis_tdata,
    input  logic                   s1_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s1_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic [1:0]             grant,
    output logic                   err_long_line
);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(MAX_LINE_BEATS - 1);

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic        err_q, err_d;

    logic src_last;
    logic wd_hit;
    logic fire;

    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tuser   = '0;
        m_axis_tdest   = '0;
        src_last       = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state_q)
            GNT0: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tuser   = s0_axis_tuser;
                m_axis_tdest   = VC0_DEST;
                src_last       = s0_axis_tlast;
                s0_axis_tready = m_axis_tready;
            end
            GNT1: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tuser   = s1_axis_tuser;
                m_axis_tdest   = VC1_DEST;
                src_last       = s1_axis_tlast;
                s1_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
        wd_hit       = (state_q != IDLE) && (beat_cnt_q == WD_LAST);
        m_axis_tlast = src_last | (wd_hit & m_axis_tvalid);
        fire         = m_axis_tvalid & m_axis_tready;
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, the input that did not own the previous grant wins.
                if (s0_axis_tvalid && (!s1_axis_tvalid || last_gnt_q)) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                    beat_cnt_d = '0;
                end else if (s1_axis_tvalid) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (src_last) begin
                        state_d = IDLE;
                    end else if (wd_hit) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign grant         = state_q;
    assign err_long_line = err_q;

endmodule

// File: tb/tb_vc_line_arbiter.sv
// Directed bench for vc_line_arbiter: a default-parameter instance and a short-watchdog
// instance (MAX_LINE_BEATS = 8) share stimulus; one of them is selected as the active DUT.
module tb_vc_line_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn;
    logic        s0_tvalid, s0_tlast, s1_tvalid, s1_tlast;
    logic [15:0] s0_tdata, s1_tdata;
    logic [0:0]  s0_tuser, s1_tuser;
    logic        m_tready;

    logic        a_s0_tready, a_s1_tready, a_m_tvalid, a_m_tlast, a_err;
    logic [15:0] a_m_tdata;
    logic [0:0]  a_m_tuser;
    logic [9:0]  a_m_tdest;
    logic [1:0]  a_grant;

    logic        b_s0_tready, b_s1_tready, b_m_tvalid, b_m_tlast, b_err;
    logic [15:0] b_m_tdata;
    logic [0:0]  b_m_tuser;
    logic [9:0]  b_m_tdest;
    logic [1:0]  b_grant;

    vc_line_arbiter dut (
        .aclk(clk), .aresetn(aresetn),
        .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(a_s0_tready), .s0_axis_tdata(s0_tdata),
        .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
        .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(a_s1_tready), .s1_axis_tdata(s1_tdata),
        .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(a_m_tdata),
        .m_axis_tlast(a_m_tlast), .m_axis_tuser(a_m_tuser), .m_axis_tdest(a_m_tdest),
        .grant(a_grant), .err_long_line(a_err)
    );

    vc_line_arbiter #(.MAX_LINE_BEATS(8)) dut_wd (
        .aclk(clk), .aresetn(aresetn),
        .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(b_s0_tready), .s0_axis_tdata(s0_tdata),
        .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
        .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(b_s1_tready), .s1_axis_tdata(s1_tdata),
        .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(b_m_tdata),
        .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser), .m_axis_tdest(b_m_tdest),
        .grant(b_grant), .err_long_line(b_err)
    );

    typedef struct packed {
        logic [9:0]  dest;
        logic [15:0] data;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        user;
    } src_t;

    localparam logic [9:0] VC0 = 10'h1e2;
    localparam logic [9:0] VC1 = 10'h1e3;

    src_t  q0[$], q1[$];
    beat_t out_q[$], exp_q[$];
    int    out_cyc[$], err_cyc[$];
    int    checks = 0, failures = 0;
    int    cyc = 0, n0 = 0;
    bit    sel_wd = 1'b0, bp = 1'b0, chk_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int src, input int id, input int b);
        return {4'(src), 4'(id), 8'(b)};
    endfunction

    task automatic drive();
        if (q0.size() > 0) begin
            s0_tvalid = 1'b1; s0_tdata = q0[0].data; s0_tlast = q0[0].last; s0_tuser = q0[0].user;
        end else begin
            s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0; s0_tuser = '0;
        end
        if (q1.size() > 0) begin
            s1_tvalid = 1'b1; s1_tdata = q1[0].data; s1_tlast = q1[0].last; s1_tuser = q1[0].user;
        end else begin
            s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0; s1_tuser = '0;
        end
        m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Sample at the falling edge, then advance the sources just after the rising edge.
    task automatic step();
        logic s0r, s1r, mv, ml, mu, er, acc0, acc1;
        logic [15:0] md;
        logic [9:0]  mdest;
        logic [1:0]  g;
        @(negedge clk);
        cyc++;
        if (sel_wd) begin
            s0r = b_s0_tready; s1r = b_s1_tready; mv = b_m_tvalid; ml = b_m_tlast;
            mu = b_m_tuser[0]; er = b_err; md = b_m_tdata; mdest = b_m_tdest; g = b_grant;
        end else begin
            s0r = a_s0_tready; s1r = a_s1_tready; mv = a_m_tvalid; ml = a_m_tlast;
            mu = a_m_tuser[0]; er = a_err; md = a_m_tdata; mdest = a_m_tdest; g = a_grant;
        end
        if (mv && m_tready) begin
            out_q.push_back(beat_t'{mdest, md, ml, mu});
            out_cyc.push_back(cyc);
        end
        if (er) err_cyc.push_back(cyc);
        if (chk_rdy) begin
            chk("s0_ready_owner", 32'(s0r), 32'(g[0] & m_tready));
            chk("s1_ready_owner", 32'(s1r), 32'(g[1] & m_tready));
        end
        acc0 = s0_tvalid & s0r;
        acc1 = s1_tvalid & s1r;
        @(posedge clk);
        #1;
        if (acc0) begin void'(q0.pop_front()); n0++; end
        if (acc1) void'(q1.pop_front());
        drive();
    endtask

    task automatic load_line(input int src, input int n, input int id);
        for (int b = 0; b < n; b++) begin
            if (src == 0) q0.push_back(src_t'{pix(0, id, b), b == n - 1, 1'b0});
            else          q1.push_back(src_t'{pix(1, id, b), b == n - 1, 1'b0});
        end
    endtask

    task automatic exp_line(input int src, input int n, input int id);
        for (int b = 0; b < n; b++)
            exp_q.push_back(beat_t'{(src == 0) ? VC0 : VC1, pix(src, id, b), b == n - 1, 1'b0});
    endtask

    task automatic run_drain(input string tag, input int budget);
        int k = 0;
        drive();
        while ((q0.size() + q1.size()) > 0 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
        repeat (3) step();
    endtask

    // gaps=1: beats of a line must be back-to-back with exactly one idle cycle between lines.
    task automatic check_stream(input string tag, input bit gaps);
        chk({tag, "_beats"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
            if (gaps && i > 0)
                chk($sformatf("%s_gap%0d", tag, i), 32'(out_cyc[i] - out_cyc[i-1]),
                    exp_q[i-1].last ? 32'd2 : 32'd1);
        end
        out_q.delete(); exp_q.delete(); out_cyc.delete(); err_cyc.delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        q0.delete(); q1.delete();
        drive();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        out_q.delete(); exp_q.delete(); out_cyc.delete(); err_cyc.delete();
        drive();
    endtask

    initial begin
        int start;
        int k;
        aresetn = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 32'(a_m_tvalid), 32'd0);
        chk("rst_grant", 32'(a_grant), 32'd0);
        chk("rst_s0_tready", 32'(a_s0_tready), 32'd0);
        chk("rst_s1_tready", 32'(a_s1_tready), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_m_tdest", 32'(a_m_tdest), 32'd0);
        chk("rst_m_tlast", 32'(a_m_tlast), 32'd0);
        chk("rst_wd_grant", 32'(b_grant), 32'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        // Reset asserted mid-way through a 100-beat s0 line.
        load_line(0, 100, 0);
        drive();
        repeat (10) step();
        chk("pre_reset_beats", 32'(out_q.size()), 32'd9);
        chk("pre_reset_grant", 32'(a_grant), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("async_rst_m_tvalid", 32'(a_m_tvalid), 32'd0);
        chk("async_rst_s0_tready", 32'(a_s0_tready), 32'd0);
        chk("async_rst_s1_tready", 32'(a_s1_tready), 32'd0);
        chk("async_rst_grant", 32'(a_grant), 32'd0);
        q0.delete();
        drive();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        out_q.delete(); out_cyc.delete(); err_cyc.delete();

        // First tie after reset goes to input 0; single-beat lines.
        load_line(0, 1, 1);
        load_line(1, 1, 1);
        exp_line(0, 1, 1);
        exp_line(1, 1, 1);
        run_drain("tie", 20);
        check_stream("tie", 1'b1);

        // Round-robin with both inputs continuously valid, 8-beat lines.
        for (int l = 0; l < 3; l++) begin
            load_line(0, 8, 2 + l);
            load_line(1, 8, 2 + l);
            exp_line(0, 8, 2 + l);
            exp_line(1, 8, 2 + l);
        end
        run_drain("rr", 200);
        check_stream("rr", 1'b1);

        // s1 becomes valid at beat 3 of a 10-beat s0 line.
        load_line(0, 10, 5);
        drive();
        start = n0;
        k = 0;
        while (n0 < start + 3 && k < 50) begin
            step();
            k++;
        end
        chk("atom_s0_beats_before_s1", 32'(n0 - start), 32'd3);
        load_line(1, 4, 5);
        exp_line(0, 10, 5);
        exp_line(1, 4, 5);
        run_drain("atom", 100);
        check_stream("atom", 1'b1);

        // Random output backpressure on 16-beat lines.
        bp = 1'b1;
        chk_rdy = 1'b1;
        load_line(0, 16, 6); load_line(0, 16, 7);
        load_line(1, 16, 6); load_line(1, 16, 7);
        exp_line(0, 16, 6); exp_line(1, 16, 6);
        exp_line(0, 16, 7); exp_line(1, 16, 7);
        run_drain("bp", 2000);
        check_stream("bp", 1'b0);
        bp = 1'b0;
        chk_rdy = 1'b0;

        // Watchdog at 8 beats: 20 beats without tlast, then 4 more ending on a real tlast
        // that coincides with the limit.
        sel_wd = 1'b1;
        do_reset();
        for (int b = 0; b < 24; b++) begin
            q0.push_back(src_t'{pix(0, 9, b), b == 23, 1'b0});
            exp_q.push_back(beat_t'{VC0, pix(0, 9, b), (b % 8) == 7, 1'b0});
        end
        run_drain("wd", 200);
        chk("wd_err_pulses", 32'(err_cyc.size()), 32'd2);
        if (err_cyc.size() >= 2 && out_cyc.size() >= 16) begin
            chk("wd_err0_cycle", 32'(err_cyc[0]), 32'(out_cyc[7] + 1));
            chk("wd_err1_cycle", 32'(err_cyc[1]), 32'(out_cyc[15] + 1));
        end
        check_stream("wd", 1'b1);

        // Passthrough of tuser/tdata and back-to-back single-beat lines.
        sel_wd = 1'b0;
        do_reset();
        q0.push_back(src_t'{16'h4c02, 1'b0, 1'b1});
        q0.push_back(src_t'{pix(0, 10, 1), 1'b0, 1'b0});
        q0.push_back(src_t'{pix(0, 10, 2), 1'b1, 1'b0});
        load_line(1, 1, 11);
        load_line(1, 1, 12);
        exp_q.push_back(beat_t'{VC0, 16'h4c02, 1'b0, 1'b1});
        exp_q.push_back(beat_t'{VC0, pix(0, 10, 1), 1'b0, 1'b0});
        exp_q.push_back(beat_t'{VC0, pix(0, 10, 2), 1'b1, 1'b0});
        exp_line(1, 1, 11);
        exp_line(1, 1, 12);
        run_drain("pass", 50);
        check_stream("pass", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
